// File: rtl/mosby_bus_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
package mosby_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic W_RD_READ  = 1'b0;
  localparam logic W_RD_WRITE = 1'b1;

  localparam int DEFAULT_ADDR_W = 16;

endpackage

// File: rtl/prio_pick.sv
// Age-aware fixed-priority picker: aged requesters first, lowest index wins.
module prio_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] aged,
  output logic [N-1:0] win
);

  logic [N-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand = (|aged) ? aged : req;
    win  = cand & (~cand + N'(1));  // isolate lowest set bit
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between N_REQ requesters with aging and RMW lock.
module mem_bus_arbiter
  import mosby_bus_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int MAX_WAIT = 7
) (
  input  logic                    clk_2,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  input  logic [N_REQ*8-1:0]      wdata_in,
  input  logic [N_REQ-1:0]        w_rd_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [7:0]              rdata,
  output logic                    busy,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    mem_w_rd,
  input  logic                    mem_rdy,
  input  logic [7:0]              mem_rdata
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  state_t            state;
  logic [OWN_W-1:0]  owner;
  logic [AGE_W-1:0]  age [N_REQ];

  logic [N_REQ-1:0]  aged;
  logic [N_REQ-1:0]  win;
  logic [N_REQ-1:0]  grant_now;
  logic [OWN_W-1:0]  win_idx;
  logic [OWN_W-1:0]  ld_idx;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_wdata;
  logic              ld_w_rd;

  always_comb begin
    aged = '0;
    for (int i = 0; i < N_REQ; i++) aged[i] = req[i] && (age[i] == AGE_MAX);
  end

  prio_pick #(.N(N_REQ)) u_pick (
    .req  (req),
    .aged (aged),
    .win  (win)
  );

  assign grant_now = (state == IDLE) ? win : '0;

  // In HOLD the owner reloads its own request; otherwise the picker's winner is loaded.
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (win[i]) win_idx = OWN_W'(i);
    ld_idx   = (state == HOLD) ? owner : win_idx;
    ld_addr  = '0;
    ld_wdata = '0;
    ld_w_rd  = W_RD_READ;
    for (int i = 0; i < N_REQ; i++) begin
      if (ld_idx == OWN_W'(i)) begin
        ld_addr  = addr_in[i*ADDR_W +: ADDR_W];
        ld_wdata = wdata_in[i*8 +: 8];
        ld_w_rd  = w_rd_in[i];
      end
    end
  end

  // NOTE: age counters are plain flops, not a RAM, so they take the async reset too.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] || gnt[i] || grant_now[i]) age[i] <= '0;
        else if (age[i] != AGE_MAX)            age[i] <= age[i] + AGE_W'(1);
      end
    end
  end

  // NOTE: sequential state uses <= so every flop sees pre-edge values of the others.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_w_rd  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= win_idx;
            gnt       <= win;
            mem_addr  <= ld_addr;
            mem_wdata <= ld_wdata;
            mem_w_rd  <= ld_w_rd;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_rdy) begin
            if (mem_w_rd == W_RD_READ) rdata <= mem_rdata;
            done   <= gnt;
            mem_en <= 1'b0;
            if (|(lock & gnt)) begin
              state <= HOLD;
            end else begin
              gnt   <= '0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        HOLD: begin
          if (|(req & gnt)) begin
            mem_addr  <= ld_addr;
            mem_wdata <= ld_wdata;
            mem_w_rd  <= ld_w_rd;
            mem_en    <= 1'b1;
            state     <= ACCESS;
          end else if (!(|(lock & gnt))) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model plus directed literals.
module tb_mem_bus_arbiter;

  localparam int N = 3;
  localparam int AW = 16;
  localparam int MAX_WAIT = 7;

  logic          clk_2 = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req, lock, w_rd_in;
  logic [N*AW-1:0] addr_in;
  logic [N*8-1:0]  wdata_in;
  logic          mem_rdy;
  logic [7:0]    mem_rdata;
  logic [N-1:0]  gnt, done;
  logic [7:0]    rdata, mem_wdata;
  logic          busy, mem_en, mem_w_rd;
  logic [AW-1:0] mem_addr;

  mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_2(clk_2), .rst_n(rst_n), .req(req), .lock(lock), .addr_in(addr_in),
    .wdata_in(wdata_in), .w_rd_in(w_rd_in), .gnt(gnt), .done(done), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_w_rd(mem_w_rd), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the bus is in its transaction, who owns it, how long each waits.
  localparam int P_FREE = 0, P_XFER = 1, P_BUBBLE = 2, P_LOCKED = 3;
  int m_phase = P_FREE;
  int m_owner = 0;
  int m_age [N] = '{default: 0};
  logic [N-1:0]  e_gnt = '0, e_done = '0;
  logic [7:0]    e_rdata = '0, e_wdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic          e_wrd = 1'b0, e_busy = 1'b0, e_en = 1'b0;

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i] && m_age[i] == MAX_WAIT) return i;
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  always @(posedge clk_2 or negedge rst_n) begin
    int g;
    logic [N-1:0] d, old_gnt;
    if (!rst_n) begin
      m_phase = P_FREE; m_owner = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      e_gnt = '0; e_done = '0; e_rdata = '0; e_wdata = '0; e_addr = '0;
      e_wrd = 1'b0; e_busy = 1'b0; e_en = 1'b0;
    end else begin
      g = -1; d = '0; old_gnt = e_gnt;
      case (m_phase)
        P_FREE: if (req != '0) begin
          g = pick(req); m_owner = g; m_phase = P_XFER;
          e_addr = addr_in[g*AW +: AW]; e_wdata = wdata_in[g*8 +: 8]; e_wrd = w_rd_in[g];
        end
        P_XFER: if (mem_rdy) begin
          if (!e_wrd) e_rdata = mem_rdata;
          d[m_owner] = 1'b1;
          m_phase = lock[m_owner] ? P_LOCKED : P_BUBBLE;
        end
        P_BUBBLE: m_phase = P_FREE;
        default: if (req[m_owner]) begin
          m_phase = P_XFER;
          e_addr = addr_in[m_owner*AW +: AW]; e_wdata = wdata_in[m_owner*8 +: 8];
          e_wrd = w_rd_in[m_owner];
        end else if (!lock[m_owner]) m_phase = P_FREE;
      endcase
      for (int i = 0; i < N; i++) begin
        if (!req[i] || old_gnt[i] || g == i) m_age[i] = 0;
        else if (m_age[i] < MAX_WAIT) m_age[i]++;
      end
      e_done = d;
      e_gnt  = (m_phase == P_XFER || m_phase == P_LOCKED) ? (3'b001 << m_owner) : '0;
      e_busy = (m_phase != P_FREE);
      e_en   = (m_phase == P_XFER);
    end
  end

  // Per-cycle compare plus event counters used by the directed tests.
  int en_cycles = 0, busy_cycles = 0;
  int done_cnt [N] = '{default: 0};
  logic [N-1:0] grant_log [$];
  logic prev_en = 1'b0;

  always @(negedge clk_2) begin
    check("gnt", gnt, e_gnt);
    check("done", done, e_done);
    check("rdata", rdata, e_rdata);
    check("busy", busy, e_busy);
    check("mem_en", mem_en, e_en);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("mem_w_rd", mem_w_rd, e_wrd);
    check("gnt_onehot0", $onehot0(gnt), 1);
    if (mem_en) en_cycles++;
    if (busy) busy_cycles++;
    for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
    if (mem_en && !prev_en) grant_log.push_back(gnt);
    prev_en = mem_en;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic clear_counts();
    en_cycles = 0; busy_cycles = 0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    grant_log.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] d,
                         input logic wr, input logic lk);
    req[i] = 1'b1; addr_in[i*AW +: AW] = a; wdata_in[i*8 +: 8] = d;
    w_rd_in[i] = wr; lock[i] = lk;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_w_rd"}, mem_w_rd, 0);
  endtask

  logic [N-1:0] exp3 [7];

  initial begin
    req = '0; lock = '0; w_rd_in = '0; addr_in = '0; wdata_in = '0;
    mem_rdy = 1'b1; mem_rdata = '0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    step(2);
    rst_n = 1'b1;
    step(2);

    // 1: single read
    clear_counts();
    set_req(1, 16'h0200, 8'h00, 1'b0, 1'b0);
    mem_rdata = 8'h5A;
    step(1);
    req = '0;
    check("t1_mem_en", mem_en, 1);
    check("t1_addr", mem_addr, 16'h0200);
    step(1);
    check("t1_done", done, 3'b010);
    check("t1_rdata", rdata, 8'h5A);
    check("t1_en_low", mem_en, 0);
    step(1);
    check("t1_idle", busy, 0);
    check("t1_en_cycles", en_cycles, 1);
    check("t1_done_cnt", done_cnt[1], 1);
    step(2);

    // 2: write with four wait states
    clear_counts();
    set_req(2, 16'h01FF, 8'h33, 1'b1, 1'b0);
    mem_rdy = 1'b0;
    step(1);
    req = '0;
    check("t2_w_rd", mem_w_rd, 1);
    check("t2_wdata", mem_wdata, 8'h33);
    step(4);
    mem_rdy = 1'b1;
    step(1);
    check("t2_done", done, 3'b100);
    check("t2_rdata_kept", rdata, 8'h5A);
    step(2);
    check("t2_en_cycles", en_cycles, 5);
    check("t2_done_cnt", done_cnt[2], 1);
    step(1);

    // 3: contention between 0 and 2, aging lets 2 through
    clear_counts();
    set_req(0, 16'h0100, 8'h00, 1'b0, 1'b0);
    set_req(2, 16'h0300, 8'h00, 1'b0, 1'b0);
    mem_rdata = 8'h21;
    step(20);
    req = '0;
    step(3);
    exp3 = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b100};
    check("t3_ngrants", grant_log.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < grant_log.size()) check($sformatf("t3_grant%0d", k), grant_log[k], exp3[k]);

    // 4: locked read-modify-write
    clear_counts();
    set_req(1, 16'h0010, 8'h00, 1'b0, 1'b1);
    mem_rdata = 8'hC3;
    step(2);
    check("t4_done1", done, 3'b010);
    check("t4_rdata", rdata, 8'hC3);
    check("t4_hold_gnt", gnt, 3'b010);
    req[1] = 1'b0;
    set_req(0, 16'h0555, 8'h00, 1'b0, 1'b0);
    step(3);
    check("t4_hold_blocks0", gnt, 3'b010);
    set_req(1, 16'h0010, 8'h11, 1'b1, 1'b0);
    step(1);
    req[1] = 1'b0;
    check("t4_wr_en", mem_en, 1);
    check("t4_wr_data", mem_wdata, 8'h11);
    check("t4_wr_gnt", gnt, 3'b010);
    step(1);
    check("t4_done2", done, 3'b010);
    step(2);
    check("t4_gnt0_after", gnt, 3'b001);
    req = '0; lock = '0;
    step(4);

    // 5: reset while the memory stalls
    clear_counts();
    set_req(0, 16'hABCD, 8'h00, 1'b0, 1'b0);
    mem_rdy = 1'b0;
    step(1);
    req = '0;
    step(1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_reset");
    step(2);
    rst_n = 1'b1;
    mem_rdy = 1'b1;
    step(1);
    check("t5_no_done", done_cnt[0], 0);
    set_req(2, 16'h1234, 8'h00, 1'b0, 1'b0);
    mem_rdata = 8'h77;
    step(1);
    req = '0;
    step(1);
    check("t5_fresh_done", done, 3'b100);
    check("t5_fresh_rdata", rdata, 8'h77);
    step(3);

    // 6: idle stretch, then random traffic under the model
    clear_counts();
    step(20);
    check("t6_idle_busy", busy_cycles, 0);
    check("t6_idle_en", en_cycles, 0);
    for (int c = 0; c < 300; c++) begin
      req = 3'($urandom);
      lock = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      w_rd_in = 3'($urandom);
      addr_in = 48'({$urandom, $urandom});
      wdata_in = 24'($urandom);
      mem_rdy = ($urandom_range(0, 2) != 0);
      mem_rdata = 8'($urandom);
      step(1);
    end
    req = '0; lock = '0; mem_rdy = 1'b1;
    step(10);
    check("t6_settled", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
